// File: rtl/mcu_bus_master_if.sv
// Local command/response port and MCU bus control pins of the bus master.
// The bidirectional data lines stay a plain inout port on the master module.
interface mcu_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic [7:0] address;
    logic       write_enable;
    logic       mcu_mstr;
    logic       fpga_ready;

    // Bus master view: takes commands, produces responses, drives the strobe.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, fpga_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        output address, write_enable, mcu_mstr
    );

    // Counterpart view: command source plus the bus responder.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, fpga_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        input  address, write_enable, mcu_mstr
    );
endinterface

// File: rtl/mcu_bus_master.sv
// Initiator of the 8-bit MCU parallel bus. Turns single-beat local commands
// into setup / strobe / release handshakes against an asynchronous
// fpga_ready acknowledge, with a bounded wait in every handshake phase.
module mcu_bus_master #(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK50,
    input  logic             rst,
    mcu_bus_master_if.master bus,
    inout  wire  [7:0]       data
);
    localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [7:0]             addr_reg, addr_next;
    logic                   we_reg, we_next;
    logic                   mstr_reg, mstr_next;
    logic                   oe_reg, oe_next;
    logic [7:0]             wdata_reg, wdata_next;
    logic [7:0]             rdata_reg, rdata_next;
    logic                   tout_reg, tout_next;
    logic                   cmd_ready_reg, cmd_ready_next;
    logic                   rsp_valid_reg, rsp_valid_next;
    logic [SW-1:0]          setup_cnt_reg, setup_cnt_next;
    logic [TW-1:0]          to_cnt_reg, to_cnt_next;
    logic [TW-1:0]          to_inc;
    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic                   rdy_s;

    // fpga_ready is asynchronous: shift it through a flop chain before use.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_next[gi] = bus.fpga_ready;
        end else begin : g_rest
            assign sync_next[gi] = sync_reg[gi-1];
        end
    end
    assign rdy_s = sync_reg[SYNC_STAGES-1];

    // Phase timeout counter saturates instead of wrapping.
    assign to_inc = (to_cnt_reg == TO_MAX) ? to_cnt_reg : to_cnt_reg + TW'(1);

    // Write data is driven only while the master owns the data lines.
    assign data             = oe_reg ? wdata_reg : 8'bz;
    assign bus.address      = addr_reg;
    assign bus.write_enable = we_reg;
    assign bus.mcu_mstr     = mstr_reg;
    assign bus.cmd_ready    = cmd_ready_reg;
    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_rdata    = rdata_reg;
    assign bus.rsp_timeout  = tout_reg;

    // State and registered outputs; reset returns the bus to its idle levels.
    always_ff @(posedge CLK50) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= 8'h00;
            we_reg        <= 1'b0;
            mstr_reg      <= 1'b0;
            oe_reg        <= 1'b0;
            wdata_reg     <= 8'h00;
            rdata_reg     <= 8'h00;
            tout_reg      <= 1'b0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            setup_cnt_reg <= '0;
            to_cnt_reg    <= '0;
            sync_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            mstr_reg      <= mstr_next;
            oe_reg        <= oe_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            tout_reg      <= tout_next;
            cmd_ready_reg <= cmd_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            setup_cnt_reg <= setup_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            sync_reg      <= sync_next;
        end
    end

    // Handshake sequencing and next values of every registered output.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        we_next        = we_reg;
        mstr_next      = mstr_reg;
        oe_next        = oe_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        tout_next      = tout_reg;
        setup_cnt_next = setup_cnt_reg;
        to_cnt_next    = to_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                we_next = 1'b0;
                oe_next = 1'b0;
                if (bus.cmd_valid && cmd_ready_reg) begin
                    addr_next      = bus.cmd_addr;
                    we_next        = bus.cmd_write;
                    oe_next        = bus.cmd_write;
                    wdata_next     = bus.cmd_wdata;
                    tout_next      = 1'b0;
                    setup_cnt_next = SETUP_LOAD;
                    to_cnt_next    = '0;
                    state_next     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_reg != '0) begin
                    setup_cnt_next = setup_cnt_reg - SW'(1);
                end else if (!rdy_s) begin
                    mstr_next   = 1'b1;
                    to_cnt_next = '0;
                    state_next  = ST_STROBE;
                end else if (to_cnt_reg >= TO_LAST) begin
                    // Acknowledge from a previous cycle never cleared: give up unstrobed.
                    tout_next  = 1'b1;
                    we_next    = 1'b0;
                    oe_next    = 1'b0;
                    state_next = ST_DONE;
                end else begin
                    to_cnt_next = to_inc;
                end
            end
            ST_STROBE: begin
                if (rdy_s) begin
                    if (!we_reg) begin
                        rdata_next = data;
                    end
                    mstr_next   = 1'b0;
                    oe_next     = 1'b0;
                    to_cnt_next = '0;
                    state_next  = ST_RELEASE;
                end else if (to_cnt_reg >= TO_LAST) begin
                    mstr_next   = 1'b0;
                    oe_next     = 1'b0;
                    tout_next   = 1'b1;
                    to_cnt_next = '0;
                    state_next  = ST_RELEASE;
                end else begin
                    to_cnt_next = to_inc;
                end
            end
            ST_RELEASE: begin
                if (!rdy_s) begin
                    we_next    = 1'b0;
                    state_next = ST_DONE;
                end else if (to_cnt_reg >= TO_LAST) begin
                    tout_next  = 1'b1;
                    we_next    = 1'b0;
                    state_next = ST_DONE;
                end else begin
                    to_cnt_next = to_inc;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // cmd_ready and rsp_valid follow the state being entered, so they never overlap.
    always_comb begin
        cmd_ready_next = (state_next == ST_IDLE);
        rsp_valid_next = (state_next == ST_DONE);
    end
endmodule

// File: tb/tb_mcu_bus_master.sv
// Randomized bench for mcu_bus_master: a behavioural bus responder with its
// own memory, and a transaction-level model predicting responses.
module tb_mcu_bus_master;
    localparam int SETUP_CYC   = 2;
    localparam int TIMEOUT_CYC = 8;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst;
    mcu_bus_master_if bus();
    wire  [7:0] data;
    logic       drv_en;
    logic [7:0] drv_val;
    logic       rs_ready;
    logic       force_ready;

    assign data = drv_en ? drv_val : 8'bz;
    pullup (data);
    assign bus.fpga_ready = rs_ready | force_ready;

    mcu_bus_master #(
        .SETUP_CYC  (SETUP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK50(clk),
        .rst  (rst),
        .bus  (bus),
        .data (data)
    );

    always #5 clk = ~clk;

    // Responder memory, write log and controls
    logic [7:0]  slave_mem [256];
    logic [15:0] log_q [$];
    logic        resp_en;
    int          resp_delay;
    int          mstr_rises;

    // Reference model
    logic [7:0]  model_mem [256];
    logic [7:0]  last_rdata;
    int          total;
    int          bad;

    // Observations of the last transaction
    logic       obs_got, obs_to, obs_rdy0, obs_we0, obs_zbad, obs_wdbad, obs_wersp;
    logic [7:0] obs_rd, obs_addr0, obs_data0;
    int         obs_rise, obs_high;

    // Behavioural responder: acknowledges a strobe after resp_delay cycles.
    initial begin
        int   rs_state;
        int   rs_cnt;
        logic mstr_prev;
        rs_state = 0; rs_cnt = 0; rs_ready = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
        mstr_prev = 1'b0; mstr_rises = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mcu_mstr === 1'b1 && !mstr_prev) mstr_rises++;
            mstr_prev = (bus.mcu_mstr === 1'b1);
            case (rs_state)
                0: if (bus.mcu_mstr === 1'b1 && resp_en) begin
                    rs_cnt = resp_delay; rs_state = 1;
                end
                1: if (bus.mcu_mstr !== 1'b1) rs_state = 0;
                   else if (rs_cnt == 0) begin
                       if (bus.write_enable === 1'b1) begin
                           slave_mem[bus.address] = data;
                           log_q.push_back({bus.address, data});
                       end else begin
                           drv_val = slave_mem[bus.address];
                           drv_en  = 1'b1;
                       end
                       rs_ready = 1'b1;
                       rs_state = 2;
                   end else rs_cnt--;
                default: if (bus.mcu_mstr !== 1'b1) begin
                    rs_ready = 1'b0; drv_en = 1'b0; rs_state = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one command and observe it up to its response (bounded).
    task automatic xact(input logic w, input logic [7:0] a, input logic [7:0] d, input int rel_k);
        int n;
        int k;
        bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        bus.cmd_valid = 1'b0;
        obs_rdy0 = bus.cmd_ready; obs_addr0 = bus.address; obs_we0 = bus.write_enable; obs_data0 = data;
        obs_got = 0; obs_to = 0; obs_rd = 8'h00; obs_rise = -1; obs_high = 0;
        obs_zbad = 0; obs_wdbad = 0; obs_wersp = 0;
        k = 0;
        while (!obs_got && k < 200) begin
            if (k == rel_k) force_ready = 1'b0;
            if (bus.mcu_mstr === 1'b1) begin
                if (obs_rise < 0) obs_rise = k;
                obs_high++;
            end
            if (w) begin
                if (bus.mcu_mstr === 1'b1 && data !== d) obs_wdbad = 1;
                if (obs_rise >= 0 && bus.mcu_mstr !== 1'b1 && data !== 8'hFF) obs_zbad = 1;
            end else if (!drv_en && data !== 8'hFF) obs_zbad = 1;
            if (bus.rsp_valid === 1'b1) begin
                obs_got = 1; obs_to = bus.rsp_timeout; obs_rd = bus.rsp_rdata; obs_wersp = bus.write_enable;
            end else begin
                tick(); k++;
            end
        end
        $display("xact %s addr=%02h wdata=%02h rsp=%0d timeout=%0d rdata=%02h strobe_at=%0d strobe_len=%0d",
                 w ? "WR" : "RD", a, d, obs_got, obs_to, obs_rd, obs_rise, obs_high);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++; if (bus.address !== 8'h00) begin bad++; $display("FAIL reset_address: got %h want 00", bus.address); end
        total++; if (bus.write_enable !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bus.write_enable); end
        total++; if (bus.mcu_mstr !== 1'b0) begin bad++; $display("FAIL reset_mstr: got %b want 0", bus.mcu_mstr); end
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        total++; if (bus.rsp_rdata !== 8'h00) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 00", bus.rsp_rdata); end
        total++; if (bus.rsp_timeout !== 1'b0) begin bad++; $display("FAIL reset_rsp_timeout: got %b want 0", bus.rsp_timeout); end
        total++; if (data !== 8'hFF) begin bad++; $display("FAIL reset_data_z: got %h want released", data); end
        rst = 1'b0;
        tick();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_write();
        resp_en = 1'b1; resp_delay = 2;
        xact(1'b1, 8'h10, 8'hA5, -1);
        model_mem[8'h10] = 8'hA5;
        total++; if (obs_rdy0 !== 1'b0) begin bad++; $display("FAIL write_ready_drop: got %b want 0", obs_rdy0); end
        total++; if (obs_addr0 !== 8'h10) begin bad++; $display("FAIL write_address: got %h want 10", obs_addr0); end
        total++; if (obs_we0 !== 1'b1) begin bad++; $display("FAIL write_we: got %b want 1", obs_we0); end
        total++; if (obs_data0 !== 8'hA5) begin bad++; $display("FAIL write_setup_data: got %h want a5", obs_data0); end
        total++; if (obs_rise != SETUP_CYC) begin bad++; $display("FAIL write_strobe_delay: got %0d want %0d", obs_rise, SETUP_CYC); end
        total++; if (obs_got !== 1'b1 || obs_to !== 1'b0) begin bad++; $display("FAIL write_rsp: got rsp=%b to=%b want 1 0", obs_got, obs_to); end
        total++; if (obs_wdbad || obs_zbad) begin bad++; $display("FAIL write_data_lines: got drive_err=%b release_err=%b want 0 0", obs_wdbad, obs_zbad); end
        total++; if (obs_wersp !== 1'b0) begin bad++; $display("FAIL write_we_done: got %b want 0", obs_wersp); end
        total++; if (slave_mem[8'h10] !== model_mem[8'h10]) begin bad++; $display("FAIL write_captured: got %h want %h", slave_mem[8'h10], model_mem[8'h10]); end
        tick();
        total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL write_rsp_pulse: got rsp=%b ready=%b want 0 1", bus.rsp_valid, bus.cmd_ready); end
    endtask

    task automatic test_read();
        resp_en = 1'b1; resp_delay = 1;
        slave_mem[8'h05] = 8'h3C; model_mem[8'h05] = 8'h3C;
        xact(1'b0, 8'h05, 8'h00, -1);
        total++; if (obs_we0 !== 1'b0 || obs_addr0 !== 8'h05) begin bad++; $display("FAIL read_setup: got we=%b addr=%h want 0 05", obs_we0, obs_addr0); end
        total++; if (obs_got !== 1'b1 || obs_to !== 1'b0) begin bad++; $display("FAIL read_rsp: got rsp=%b to=%b want 1 0", obs_got, obs_to); end
        total++; if (obs_rd !== model_mem[8'h05]) begin bad++; $display("FAIL read_rdata: got %h want %h", obs_rd, model_mem[8'h05]); end
        total++; if (obs_zbad) begin bad++; $display("FAIL read_data_z: got master drive want released"); end
        last_rdata = model_mem[8'h05];
    endtask

    task automatic test_timeout();
        resp_en = 1'b0;
        xact(1'b0, 8'h07, 8'h00, -1);
        total++; if (obs_got !== 1'b1 || obs_to !== 1'b1) begin bad++; $display("FAIL timeout_rsp: got rsp=%b to=%b want 1 1", obs_got, obs_to); end
        total++; if (obs_high != TIMEOUT_CYC) begin bad++; $display("FAIL timeout_strobe_len: got %0d want %0d", obs_high, TIMEOUT_CYC); end
        total++; if (obs_rd !== last_rdata) begin bad++; $display("FAIL timeout_rdata_hold: got %h want %h", obs_rd, last_rdata); end
        resp_en = 1'b1;
    endtask

    task automatic test_stale();
        resp_en = 1'b1; resp_delay = 0;
        force_ready = 1'b1;
        tick(); tick(); tick();
        xact(1'b1, 8'h20, 8'h5A, 3);
        model_mem[8'h20] = 8'h5A;
        total++; if (obs_rise != 3 + SYNC_STAGES + 1) begin bad++; $display("FAIL stale_strobe_at: got %0d want %0d", obs_rise, 3 + SYNC_STAGES + 1); end
        total++; if (obs_got !== 1'b1 || obs_to !== 1'b0) begin bad++; $display("FAIL stale_rsp: got rsp=%b to=%b want 1 0", obs_got, obs_to); end
        total++; if (slave_mem[8'h20] !== model_mem[8'h20]) begin bad++; $display("FAIL stale_captured: got %h want %h", slave_mem[8'h20], model_mem[8'h20]); end
        force_ready = 1'b1;
        tick(); tick(); tick();
        xact(1'b1, 8'h21, 8'h77, -1);
        total++; if (obs_got !== 1'b1 || obs_to !== 1'b1) begin bad++; $display("FAIL stale_timeout_rsp: got rsp=%b to=%b want 1 1", obs_got, obs_to); end
        total++; if (obs_rise != -1) begin bad++; $display("FAIL stale_timeout_no_strobe: got %0d want -1", obs_rise); end
        total++; if (data !== 8'hFF || obs_wersp !== 1'b0) begin bad++; $display("FAIL stale_timeout_bus: got data=%h we=%b want released 0", data, obs_wersp); end
        force_ready = 1'b0;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        int n;
        resp_en = 1'b0;
        bus.cmd_write = 1'b1; bus.cmd_addr = 8'h33; bus.cmd_wdata = 8'h44; bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus.mcu_mstr !== 1'b1 && n < 50) begin tick(); n++; end
        total++; if (bus.mcu_mstr !== 1'b1) begin bad++; $display("FAIL rstmid_strobe_reached: got %b want 1", bus.mcu_mstr); end
        rst = 1'b1;
        tick();
        total++; if (bus.mcu_mstr !== 1'b0 || bus.write_enable !== 1'b0) begin bad++; $display("FAIL rstmid_bus: got mstr=%b we=%b want 0 0", bus.mcu_mstr, bus.write_enable); end
        total++; if (data !== 8'hFF) begin bad++; $display("FAIL rstmid_data_z: got %h want released", data); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp: got %b want 0", bus.rsp_valid); end
        rst = 1'b0;
        tick();
        total++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_release: got ready=%b rsp=%b want 1 0", bus.cmd_ready, bus.rsp_valid); end
        total++; if (bus.rsp_rdata !== 8'h00) begin bad++; $display("FAIL rstmid_rdata: got %h want 00", bus.rsp_rdata); end
        last_rdata = 8'h00;
        resp_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int   n;
        int   rises0;
        logic got;
        resp_en = 1'b1; resp_delay = 0;
        log_q.delete();
        rises0 = mstr_rises;
        bus.cmd_write = 1'b1; bus.cmd_addr = 8'h01; bus.cmd_wdata = 8'h11; bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        bus.cmd_addr = 8'h02; bus.cmd_wdata = 8'h22;
        got = 0; n = 0;
        while (!got && n < 200) begin
            if (bus.rsp_valid === 1'b1) got = 1; else begin tick(); n++; end
        end
        total++; if (!got || bus.rsp_timeout !== 1'b0) begin bad++; $display("FAIL b2b_first_rsp: got rsp=%b to=%b want 1 0", got, bus.rsp_timeout); end
        $display("xact WR addr=01 wdata=11 rsp=%0d (back-to-back first)", got);
        tick();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_rsp: got %b want 1", bus.cmd_ready); end
        tick();
        bus.cmd_valid = 1'b0;
        total++; if (bus.cmd_ready !== 1'b0 || bus.address !== 8'h02) begin bad++; $display("FAIL b2b_second_accept: got ready=%b addr=%h want 0 02", bus.cmd_ready, bus.address); end
        got = 0; n = 0;
        while (!got && n < 200) begin
            if (bus.rsp_valid === 1'b1) got = 1; else begin tick(); n++; end
        end
        total++; if (!got || bus.rsp_timeout !== 1'b0) begin bad++; $display("FAIL b2b_second_rsp: got rsp=%b to=%b want 1 0", got, bus.rsp_timeout); end
        $display("xact WR addr=02 wdata=22 rsp=%0d (back-to-back second)", got);
        total++; if (mstr_rises - rises0 != 2) begin bad++; $display("FAIL b2b_strobes: got %0d want 2", mstr_rises - rises0); end
        total++; if (log_q.size() != 2) begin bad++; $display("FAIL b2b_log_size: got %0d want 2", log_q.size()); end
        else begin
            total++; if (log_q[0] !== 16'h0111 || log_q[1] !== 16'h0222) begin bad++; $display("FAIL b2b_order: got %h %h want 0111 0222", log_q[0], log_q[1]); end
        end
        model_mem[8'h01] = 8'h11; model_mem[8'h02] = 8'h22;
    endtask

    task automatic test_random();
        logic       w;
        logic [7:0] a, d, exp_rd;
        logic       exp_to;
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            resp_en = ($urandom_range(0, 7) != 0);
            resp_delay = $urandom_range(0, 3);
            exp_to = !resp_en;
            xact(w, a, d, -1);
            if (w && !exp_to) model_mem[a] = d;
            exp_rd = (!w && !exp_to) ? model_mem[a] : last_rdata;
            total++; if (obs_got !== 1'b1 || obs_to !== exp_to) begin bad++; $display("FAIL rand_rsp[%0d]: got rsp=%b to=%b want 1 %b", i, obs_got, obs_to, exp_to); end
            total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, obs_rd, exp_rd); end
            total++; if (obs_rise != SETUP_CYC) begin bad++; $display("FAIL rand_strobe_at[%0d]: got %0d want %0d", i, obs_rise, SETUP_CYC); end
            total++; if (obs_zbad || obs_wdbad || obs_wersp !== 1'b0) begin bad++; $display("FAIL rand_bus[%0d]: got release_err=%b drive_err=%b we=%b want 0 0 0", i, obs_zbad, obs_wdbad, obs_wersp); end
            last_rdata = exp_rd;
        end
        resp_en = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; force_ready = 1'b0; resp_en = 1'b1; resp_delay = 0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_wdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 8'($urandom);
            model_mem[i] = slave_mem[i];
        end
        last_rdata = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_stale();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
